// File: rtl/irq_pkg.sv
// Shared definitions for the IO-bank interrupt controller: register map,
// source limits and the priority-vector encoder.
package irq_pkg;

    localparam logic [2:0] IRQ_REG_PEND   = 3'd0;
    localparam logic [2:0] IRQ_REG_ENABLE = 3'd1;
    localparam logic [2:0] IRQ_REG_MODE   = 3'd2;
    localparam logic [2:0] IRQ_REG_ACTIVE = 3'd3;
    localparam logic [2:0] IRQ_REG_VECTOR = 3'd4;
    localparam logic [2:0] IRQ_REG_FORCE  = 3'd5;
    localparam logic [2:0] IRQ_REG_CTRL   = 3'd6;

    localparam int IRQ_MAX_SRC  = 8;
    localparam int IRQ_VEC_NONE = 7;

    // Lowest-numbered active source wins; bit 7 flags "nothing active".
    function automatic logic [7:0] irq_vector(input logic [7:0] act);
        logic [7:0] v;
        v = 8'h00;
        v[IRQ_VEC_NONE] = 1'b1;
        for (int i = IRQ_MAX_SRC - 1; i >= 0; i--) begin
            if (act[i]) v = 8'(i);
        end
        return v;
    endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Per-source synchroniser with one-clock history flop.
// rise_o is a single-clock pulse; level_o is the delayed synced level so both modes share latency.
module irq_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic src_i,
    output logic rise_o,
    output logic level_o
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync[0] <= src_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign rise_o  = sync[SYNC_STAGES-1] & ~prev;
    assign level_o = prev;

endmodule

// File: rtl/irq_controller.sv
// Shares the CPU IRQ line among up to eight sources with edge/level modes, masking and a priority vector.
// Optional FORCE register (software-set latches) is built only when IRQ_FORCE_EN is defined.
module irq_controller #(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               R_W_n,
    input  logic [2:0]         reg_addr_i,
    input  logic [7:0]         data_i,
    input  logic               irq_cs,
    input  logic [NUM_SRC-1:0] irq_src_i,
    output logic [7:0]         data_o,
    output logic               irq_o
);
    import irq_pkg::*;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] level;
    logic [NUM_SRC-1:0] latch_q;
    logic [NUM_SRC-1:0] latch_d;
    logic [NUM_SRC-1:0] enable_q;
    logic [NUM_SRC-1:0] mode_q;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] active;
    logic               ctrl_q;
    logic               wr;
    logic [7:0]         pend8;
    logic [7:0]         enable8;
    logic [7:0]         mode8;
    logic [7:0]         active8;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        irq_edge_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .src_i  (irq_src_i[i]),
            .rise_o (rise[i]),
            .level_o(level[i])
        );
    end

    assign wr     = irq_cs & ~R_W_n;
    assign pend   = (latch_q & mode_q) | (level & ~mode_q);
    assign active = pend & enable_q;

    // Clears are applied first so a same-cycle set (edge or force) always wins.
    always_comb begin
        latch_d = latch_q;
        if (wr && reg_addr_i == IRQ_REG_PEND) begin
            latch_d = latch_d & ~(data_i[NUM_SRC-1:0] & mode_q);
        end
        if (wr && reg_addr_i == IRQ_REG_MODE) begin
            latch_d = latch_d & data_i[NUM_SRC-1:0];
        end
`ifdef IRQ_FORCE_EN
        if (wr && reg_addr_i == IRQ_REG_FORCE) begin
            latch_d = latch_d | data_i[NUM_SRC-1:0];
        end
`endif
        latch_d = latch_d | (rise & mode_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            latch_q  <= '0;
            enable_q <= '0;
            mode_q   <= '1;
            ctrl_q   <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            latch_q <= latch_d;
            irq_o   <= ctrl_q & (|active);
            if (wr) begin
                case (reg_addr_i)
                    IRQ_REG_ENABLE: enable_q <= data_i[NUM_SRC-1:0];
                    IRQ_REG_MODE:   mode_q   <= data_i[NUM_SRC-1:0];
                    IRQ_REG_CTRL:   ctrl_q   <= data_i[0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        pend8   = '0;
        enable8 = '0;
        mode8   = '0;
        active8 = '0;
        pend8[NUM_SRC-1:0]   = pend;
        enable8[NUM_SRC-1:0] = enable_q;
        mode8[NUM_SRC-1:0]   = mode_q;
        active8[NUM_SRC-1:0] = active;
    end

    always_comb begin
        data_o = 8'h00;
        case (reg_addr_i)
            IRQ_REG_PEND:   data_o = pend8;
            IRQ_REG_ENABLE: data_o = enable8;
            IRQ_REG_MODE:   data_o = mode8;
            IRQ_REG_ACTIVE: data_o = active8;
            IRQ_REG_VECTOR: data_o = irq_vector(active8);
            IRQ_REG_CTRL:   data_o = {7'b0, ctrl_q};
            default:        data_o = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: register table plus hand-written timing sequences.
module tb_irq_controller;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       R_W_n;
    logic [2:0] reg_addr_i;
    logic [7:0] data_i;
    logic       irq_cs;
    logic [7:0] irq_src_i;
    logic [7:0] data_o;
    logic       irq_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    irq_controller #(
        .NUM_SRC    (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .R_W_n     (R_W_n),
        .reg_addr_i(reg_addr_i),
        .data_i    (data_i),
        .irq_cs    (irq_cs),
        .irq_src_i (irq_src_i),
        .data_o    (data_o),
        .irq_o     (irq_o)
    );

    typedef struct {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] dat;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[18];

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        irq_cs     = 1'b1;
        R_W_n      = 1'b0;
        reg_addr_i = a;
        data_i     = d;
        @(posedge clk_i);
        #1;
        irq_cs = 1'b0;
        R_W_n  = 1'b1;
    endtask

    task automatic chk_reg(input string nm, input logic [2:0] a, input logic [7:0] e);
        reg_addr_i = a;
        #1;
        checks++;
        if (data_o !== e) begin
            errors++;
            $display("FAIL %s: data_o=%02h expected %02h", nm, data_o, e);
        end
    endtask

    task automatic chk_irq(input string nm, input logic e);
        checks++;
        if (irq_o !== e) begin
            errors++;
            $display("FAIL %s: irq_o=%0b expected %0b", nm, irq_o, e);
        end
    endtask

    initial begin
        // reset values, then register read/write behaviour
        tbl[0]  = '{1'b0, 3'd0, 8'h00, 8'h00};
        tbl[1]  = '{1'b0, 3'd1, 8'h00, 8'h00};
        tbl[2]  = '{1'b0, 3'd2, 8'h00, 8'hFF};
        tbl[3]  = '{1'b0, 3'd3, 8'h00, 8'h00};
        tbl[4]  = '{1'b0, 3'd4, 8'h00, 8'h80};
        tbl[5]  = '{1'b0, 3'd5, 8'h00, 8'h00};
        tbl[6]  = '{1'b0, 3'd6, 8'h00, 8'h00};
        tbl[7]  = '{1'b0, 3'd7, 8'h00, 8'h00};
        tbl[8]  = '{1'b1, 3'd1, 8'hA5, 8'h00};
        tbl[9]  = '{1'b0, 3'd1, 8'h00, 8'hA5};
        tbl[10] = '{1'b1, 3'd2, 8'h3C, 8'h00};
        tbl[11] = '{1'b0, 3'd2, 8'h00, 8'h3C};
        tbl[12] = '{1'b1, 3'd6, 8'hFF, 8'h00};
        tbl[13] = '{1'b0, 3'd6, 8'h00, 8'h01};
        tbl[14] = '{1'b1, 3'd7, 8'h55, 8'h00};
        tbl[15] = '{1'b0, 3'd7, 8'h00, 8'h00};
        tbl[16] = '{1'b1, 3'd2, 8'hFF, 8'h00};
        tbl[17] = '{1'b1, 3'd1, 8'h00, 8'h00};

        rst_i      = 1'b1;
        R_W_n      = 1'b1;
        reg_addr_i = 3'd0;
        data_i     = 8'h00;
        irq_cs     = 1'b0;
        irq_src_i  = 8'h00;
        repeat (3) step();
        rst_i = 1'b0;
        step();
        chk_irq("reset_irq", 1'b0);

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].wr) begin
                wr_reg(tbl[i].addr, tbl[i].dat);
            end else begin
                chk_reg($sformatf("table[%0d]", i), tbl[i].addr, tbl[i].exp);
                step();
            end
        end
        wr_reg(3'd6, 8'h00);
        chk_reg("ctrl_cleared", 3'd6, 8'h00);

        // single edge source: irq_o rises three edges after first sample
        wr_reg(3'd1, 8'h01);
        wr_reg(3'd6, 8'h01);
        irq_src_i = 8'h01;
        step();
        step();
        step();
        chk_irq("edge_lat_k2", 1'b0);
        step();
        chk_irq("edge_lat_k3", 1'b1);
        chk_reg("edge_vector", 3'd4, 8'h00);
        irq_src_i = 8'h00;
        wr_reg(3'd0, 8'h01);
        chk_reg("w1c_pend", 3'd0, 8'h00);
        chk_irq("w1c_irq_w", 1'b1);
        step();
        chk_irq("w1c_irq_w1", 1'b0);

        // two simultaneous edges, priority vector walk
        wr_reg(3'd1, 8'hFF);
        irq_src_i = 8'h24;
        repeat (4) step();
        irq_src_i = 8'h00;
        repeat (3) step();
        chk_reg("prio_pend", 3'd0, 8'h24);
        chk_reg("prio_vec2", 3'd4, 8'h02);
        chk_irq("prio_irq", 1'b1);
        wr_reg(3'd0, 8'h04);
        chk_reg("prio_vec5", 3'd4, 8'h05);
        wr_reg(3'd0, 8'h20);
        chk_reg("prio_none", 3'd4, 8'h80);
        step();
        chk_irq("prio_irq_off", 1'b0);

        // level mode: W1C ignored, fall latency
        wr_reg(3'd2, 8'h00);
        wr_reg(3'd1, 8'h08);
        irq_src_i = 8'h08;
        step();
        step();
        step();
        chk_irq("lvl_lat_k2", 1'b0);
        step();
        chk_irq("lvl_lat_k3", 1'b1);
        wr_reg(3'd0, 8'h08);
        chk_reg("lvl_w1c_pend", 3'd0, 8'h08);
        step();
        chk_irq("lvl_w1c_irq", 1'b1);
        irq_src_i = 8'h00;
        step();
        step();
        step();
        chk_irq("lvl_fall_k2", 1'b1);
        step();
        chk_irq("lvl_fall_k3", 1'b0);

        // edge and W1C on the same edge: set wins
        wr_reg(3'd2, 8'hFF);
        wr_reg(3'd1, 8'h02);
        irq_src_i = 8'h02;
        repeat (4) step();
        irq_src_i = 8'h00;
        repeat (3) step();
        chk_reg("race_pre", 3'd0, 8'h02);
        irq_src_i = 8'h02;
        step();
        step();
        wr_reg(3'd0, 8'h02);
        chk_reg("race_set_wins", 3'd0, 8'h02);
        step();
        chk_irq("race_irq", 1'b1);

        // reset mid-pending, then a held source latches after release
        rst_i = 1'b1;
        step();
        chk_reg("rst_pend", 3'd0, 8'h00);
        chk_irq("rst_irq", 1'b0);
        rst_i = 1'b0;
        step();
        step();
        chk_reg("post_rst_k1", 3'd0, 8'h00);
        step();
        chk_reg("post_rst_k2", 3'd0, 8'h02);
        irq_src_i = 8'h00;
        repeat (4) step();
        wr_reg(3'd0, 8'h02);
        chk_reg("clean_pend", 3'd0, 8'h00);

`ifdef IRQ_FORCE_EN
        wr_reg(3'd2, 8'h00);
        wr_reg(3'd5, 8'h40);
        chk_reg("force_lvl_hidden", 3'd0, 8'h00);
        wr_reg(3'd2, 8'hFF);
        chk_reg("force_pend", 3'd0, 8'h40);
        wr_reg(3'd1, 8'h40);
        wr_reg(3'd6, 8'h01);
        chk_irq("force_irq_w", 1'b0);
        step();
        chk_irq("force_irq_w1", 1'b1);
`else
        wr_reg(3'd5, 8'h40);
        chk_reg("noforce_reg5", 3'd5, 8'h00);
        chk_reg("noforce_pend", 3'd0, 8'h00);
        wr_reg(3'd1, 8'h40);
        wr_reg(3'd6, 8'h01);
        step();
        chk_irq("noforce_irq", 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller that shares the 65C02 `IRQ` input among up to eight peripheral interrupt sources (UART, timer, SD card, video, ...). It sits in the IO page as its own IO bank, selected by `irq_cs` from the address decoder, and is accessed like the other peripherals. Each source is synchronised, latched or passed through as a level, and masked. The controller drives a single active-high `irq_o` to the CPU and exposes a priority-encoded vector register.

## Interface
- `NUM_SRC`, default 8: number of interrupt sources, 1..8; unused register bits read 0.
- `SYNC_STAGES`, default 2: synchroniser depth per source, ≥1.
- `clk_i`  in  1  system clock; same clock as the CPU.
- `rst_i`  in  1  reset, synchronous, active-high.
- `R_W_n`  in  1  registered CPU read/write_n.
- `reg_addr_i`  in  3  registered CPU address bits [2:0].
- `data_i`  in  8  CPU write data.
- `irq_cs`  in  1  bank select from the address decoder.
- `irq_src_i`  in  NUM_SRC  raw source requests, active-high.
- `data_o`  out  8  read data, combinational decode of `reg_addr_i`.
- `irq_o`  out  1  registered interrupt request to the CPU, active-high.

## Operation
- A write occurs on a clock edge when `irq_cs`=1 and `R_W_n`=0. Reads have no side effects.
- Register map at `reg_addr_i`:
  - 0 PEND (R, W1C): edge-mode bits show the latch; level-mode bits show the synced input. W1C affects edge-mode bits only.
  - 1 ENABLE (RW): reset 0x00.
  - 2 MODE (RW): 1 = rising-edge, 0 = level. Reset 0xFF. Writing clears the latch of every bit whose new mode is 0.
  - 3 ACTIVE (R): PEND & ENABLE.
  - 4 VECTOR (R): `[2:0]` is the index of the lowest-numbered ACTIVE bit; bit7=1 and `[2:0]`=0 when none are active.
  - 5 FORCE (W): only when `IRQ_FORCE_EN` is defined; see Configuration.
  - 6 CTRL (RW): bit0 is the global enable, reset 0; other bits read 0.
  - 7: reads 0x00; writes are ignored.
- Edge detect: a rising edge is `sync_out & ~prev`, where `prev` is `sync_out` delayed one clock.
  - An edge in edge mode sets the latch.
  - If an edge and a W1C hit the same bit in the same cycle, set wins and the bit stays 1.
- `irq_o` is registered: it takes `CTRL[0] & |ACTIVE` on every clock.
- Reset clears all synchronisers, `prev`, latches, ENABLE, CTRL and `irq_o`, and sets MODE to 0xFF. `data_o` then reads the reset register values.
  - Reset asserted mid-pending discards all latched requests.
  - `prev` resets to 0, so a source held high through reset latches one edge after release. This is intended.

## Timing
- Source high first sampled at edge k: `sync_out` is high after edge k+SYNC_STAGES−1, the latch sets at edge k+SYNC_STAGES, and `irq_o` rises at edge k+SYNC_STAGES+1. With the default this is 3 clocks.
- Level mode has the same latency. `irq_o` falls SYNC_STAGES+1 clocks after the source drops.
- A W1C write at edge w: PEND reads 0 from w+1, and `irq_o` drops at w+1 if nothing else is active.
- ENABLE or CTRL write at edge w: `irq_o` updates at edge w+1.
- Register writes take effect at the write edge. `data_o` reflects new values in the following cycle.
- Pulses shorter than one clock may be missed. Sources must hold ≥1 clock.

## Configuration
- `IRQ_FORCE_EN` defined:
  - Register 5 (FORCE) exists. Writing a 1 sets the latch of that bit in the same edge as the write, regardless of mode.
  - A forced level-mode bit stays invisible in PEND until MODE is switched to edge.
  - If FORCE and W1C target the same bit in the same cycle, set wins.
- Not defined: register 5 reads 0 and writes are ignored, and no force logic is synthesised.

## Structure
- Package `irq_pkg`:
  - register address localparams: `IRQ_REG_PEND`..`IRQ_REG_CTRL`;
  - `IRQ_MAX_SRC`=8;
  - the `IRQ_VEC_NONE` bit position (7).
- Sub-module `irq_edge_sync`: one instance per source (SYNC_STAGES flops, `prev` flop, `rise_o`/`level_o` outputs), instantiated with a generate loop.
- Top-level integration: assign IO bank 0x0005 in `addr_decoder`, connect `irq_o` to the CPU `IRQ`, and add `irq_cs` to the read mux.

## Test plan
1. Reset, then read all registers → PEND=0x00, ENABLE=0x00, MODE=0xFF, VECTOR=0x80, CTRL=0x00; `irq_o`=0.
2. ENABLE=0x01, CTRL=0x01, pulse `irq_src_i[0]` high at edge k → `irq_o`=1 at edge k+3; VECTOR=0x00. Write PEND=0x01 → `irq_o`=0 next cycle.
3. ENABLE=0xFF, CTRL=0x01, edges on sources 5 and 2 in the same cycle → VECTOR=0x02. W1C 0x04 → VECTOR=0x05. W1C 0x20 → VECTOR=0x80.
4. MODE=0x00 (all level), ENABLE=0x08, CTRL=0x01, hold src3 high → W1C 0x08 has no effect and `irq_o` stays 1. Drop src3 → `irq_o`=0 three clocks later.
5. Edge on src1 in the same cycle as W1C 0x02 → PEND bit1 remains 1. Reset asserted with PEND=0x02 → PEND=0x00 and `irq_o`=0 after one edge.
6. With `IRQ_FORCE_EN`, write FORCE=0x40, ENABLE=0x40, CTRL=0x01 → PEND=0x40 and `irq_o`=1 next cycle. Without the macro, register 5 reads 0x00 and PEND stays 0x00.
